// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, MIPS opcode/funct constants and
// the issue-entry record passed from the issue stage to the ALU.
package alu_pkg;

  // ALU operation codes, shared with the ALU itself
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SUBU = 4'b1001;
  localparam logic [3:0] ALU_ADDU = 4'b1011;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shmt;
    logic [4:0]  dest;
  } issue_entry_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of one MIPS R/I-type instruction plus its register
// operands into an ALU issue entry. Unknown encodings raise illegal.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic [31:0]  rs_data,
  input  logic [31:0]  rt_data,
  output issue_entry_t entry,
  output logic         illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_rs_idx;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};
  // rs index is resolved by the register file; only its data is used here
  assign unused_rs_idx = ^instr[25:21];

  // Opcode/funct decode into ALU op and operand selection
  always_comb begin
    entry   = '0;
    illegal = 1'b0;
    if (opcode == OPC_RTYPE) begin
      entry.op_a = rs_data;
      entry.op_b = rt_data;
      entry.shmt = instr[10:6];
      entry.dest = instr[15:11];
      unique case (funct)
        FN_AND:  entry.alu_op = ALU_AND;
        FN_OR:   entry.alu_op = ALU_OR;
        FN_ADD:  entry.alu_op = ALU_ADD;
        FN_SUB:  entry.alu_op = ALU_SUB;
        FN_NOR:  entry.alu_op = ALU_NOR;
        FN_XOR:  entry.alu_op = ALU_XOR;
        FN_SLT:  entry.alu_op = ALU_SLT;
        FN_SUBU: entry.alu_op = ALU_SUBU;
        FN_ADDU: entry.alu_op = ALU_ADDU;
        FN_SLL: begin
          entry.alu_op = ALU_SLL;
          entry.op_a   = rt_data;
        end
        FN_SRL: begin
          entry.alu_op = ALU_SRL;
          entry.op_a   = rt_data;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      entry.op_a = rs_data;
      entry.dest = instr[20:16];
      entry.shmt = 5'd0;
      unique case (opcode)
        OPC_ADDI:  begin entry.alu_op = ALU_ADD;  entry.op_b = imm_sext; end
        OPC_ADDIU: begin entry.alu_op = ALU_ADDU; entry.op_b = imm_sext; end
        OPC_SLTI:  begin entry.alu_op = ALU_SLT;  entry.op_b = imm_sext; end
        OPC_ANDI:  begin entry.alu_op = ALU_AND;  entry.op_b = imm_zext; end
        OPC_ORI:   begin entry.alu_op = ALU_OR;   entry.op_b = imm_zext; end
        OPC_XORI:  begin entry.alu_op = ALU_XOR;  entry.op_b = imm_zext; end
        default:   illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an instruction and holds the result in an output
// (head) register backed by a one-entry skid buffer. in_ready depends only
// on registered skid occupancy, so out_ready never reaches it combinationally.
// Optional build macro ISSUE_ILLEGAL_CNT_EN adds a saturating illegal_cnt output.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  ALU_OP,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  shmt,
  output logic [4:0]  dest,
`ifdef ISSUE_ILLEGAL_CNT_EN
  output logic [15:0] illegal_cnt,
`endif
  output logic        illegal
);

  issue_entry_t dec_entry;
  logic         dec_illegal;

  issue_entry_t head_q, head_d;
  issue_entry_t skid_q, skid_d;
  logic         head_valid_q, head_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         illegal_q, illegal_d;

  logic accept;
  logic consume;
  logic legal_acc;

  alu_decode u_decode (
    .instr   (instr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .entry   (dec_entry),
    .illegal (dec_illegal)
  );

  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign consume   = head_valid_q & out_ready;
  assign legal_acc = accept & ~dec_illegal;

  // Head/skid occupancy and data movement; flush overrides everything
  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    illegal_d    = 1'b0;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      illegal_d = accept & dec_illegal;
      if (consume) begin
        // skid occupied implies no accept this cycle (in_ready low)
        if (skid_valid_q) begin
          head_d       = skid_q;
          skid_valid_d = 1'b0;
        end else if (legal_acc) begin
          head_d       = dec_entry;
          head_valid_d = 1'b1;
        end else begin
          head_valid_d = 1'b0;
        end
      end else if (legal_acc) begin
        if (!head_valid_q) begin
          head_d       = dec_entry;
          head_valid_d = 1'b1;
        end else begin
          skid_d       = dec_entry;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      illegal_q    <= illegal_d;
    end
  end

`ifdef ISSUE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt_q, illegal_cnt_d;

  // Saturating count of illegal pulses; survives flush
  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (illegal_d && (illegal_cnt_q != 16'hFFFF))
      illegal_cnt_d = illegal_cnt_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) illegal_cnt_q <= 16'h0000;
    else          illegal_cnt_q <= illegal_cnt_d;
  end

  assign illegal_cnt = illegal_cnt_q;
`endif

  assign out_valid = head_valid_q;
  assign ALU_OP    = head_q.alu_op;
  assign op_a      = head_q.op_a;
  assign op_b      = head_q.op_b;
  assign shmt      = head_q.shmt;
  assign dest      = head_q.dest;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ALU_OP;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shmt;
  logic [4:0]  dest;
  logic        illegal;
`ifdef ISSUE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  alu_issue_stage dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_OP    (ALU_OP),
    .op_a      (op_a),
    .op_b      (op_b),
    .shmt      (shmt),
    .dest      (dest),
`ifdef ISSUE_ILLEGAL_CNT_EN
    .illegal_cnt (illegal_cnt),
`endif
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] rs,
                       input logic [31:0] rt);
    in_valid = v;
    instr    = i;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  task automatic chk_entry(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh, input logic [4:0] d);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".op"},    {28'd0, ALU_OP}, {28'd0, op});
    chk({tag, ".op_a"},  op_a, a);
    chk({tag, ".op_b"},  op_b, b);
    chk({tag, ".shmt"},  {27'd0, shmt}, {27'd0, sh});
    chk({tag, ".dest"},  {27'd0, dest}, {27'd0, d});
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #12;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst.illegal",   {31'd0, illegal}, 32'd0);
    chk("rst.op",        {28'd0, ALU_OP}, 32'd0);
    chk("rst.op_a",      op_a, 32'd0);
`ifdef ISSUE_ILLEGAL_CNT_EN
    chk("rst.cnt",       {16'd0, illegal_cnt}, 32'd0);
`endif
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    tick();

    // Back-to-back decode with out_ready high: one per cycle, 1-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'h00221820, 32'd7, 32'd5);          // add $3,$1,$2
    tick();
    chk_entry("add", 4'b0010, 32'd7, 32'd5, 5'd0, 5'd3);
    drive(1'b1, 32'h2022FFFF, 32'd7, 32'd5);          // addi $2,$1,-1
    tick();
    chk_entry("addi", 4'b0010, 32'd7, 32'hFFFFFFFF, 5'd0, 5'd2);
    drive(1'b1, 32'h3022FFFF, 32'd7, 32'd5);          // andi $2,$1,0xFFFF
    tick();
    chk_entry("andi", 4'b0000, 32'd7, 32'h0000FFFF, 5'd0, 5'd2);
    drive(1'b1, 32'h000218C0, 32'd99, 32'd5);         // sll $3,$2,3
    tick();
    chk_entry("sll", 4'b0111, 32'd5, 32'd5, 5'd3, 5'd3);
    drive(1'b1, 32'h00021882, 32'd99, 32'h80000000);  // srl $3,$2,2
    tick();
    chk_entry("srl", 4'b1000, 32'h80000000, 32'h80000000, 5'd2, 5'd3);
    drive(1'b1, 32'h34228000, 32'h12345678, 32'd0);   // ori $2,$1,0x8000
    tick();
    chk_entry("ori", 4'b0001, 32'h12345678, 32'h00008000, 5'd0, 5'd2);
    drive(1'b1, 32'h00221823, 32'd1, 32'd2);          // subu $3,$1,$2
    tick();
    chk_entry("subu", 4'b1001, 32'd1, 32'd2, 5'd0, 5'd3);

    // Illegal opcode 0x3F: consumed, never issued, one-cycle pulse
    drive(1'b1, 32'hFC000000, 32'd1, 32'd2);
    tick();
    chk("ill_op.out_valid", {31'd0, out_valid}, 32'd0);
    chk("ill_op.illegal",   {31'd0, illegal}, 32'd1);
`ifdef ISSUE_ILLEGAL_CNT_EN
    chk("ill_op.cnt",       {16'd0, illegal_cnt}, 32'd1);
`endif
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();
    chk("ill_op.pulse_end", {31'd0, illegal}, 32'd0);
    // Illegal R-type funct 0x3F
    drive(1'b1, 32'h0000003F, 32'd0, 32'd0);
    tick();
    chk("ill_fn.illegal",   {31'd0, illegal}, 32'd1);
    chk("ill_fn.out_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();
    chk("ill_fn.pulse_end", {31'd0, illegal}, 32'd0);
`ifdef ISSUE_ILLEGAL_CNT_EN
    chk("ill_fn.cnt",       {16'd0, illegal_cnt}, 32'd2);
`endif

    // Stall: three back-to-back adds, tags in rs_data
    out_ready = 1'b0;
    drive(1'b1, 32'h00221820, 32'h11, 32'd0);
    tick();
    chk("stall.c1.in_ready", {31'd0, in_ready}, 32'd1);
    chk("stall.c1.op_a",     op_a, 32'h11);
    drive(1'b1, 32'h00221820, 32'h22, 32'd0);
    tick();
    chk("stall.c2.in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall.c2.op_a",     op_a, 32'h11);
    drive(1'b1, 32'h00221820, 32'h33, 32'd0);
    tick();
    chk("stall.c3.in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall.c3.op_a",     op_a, 32'h11);
    chk("stall.c3.valid",    {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("drain.1.op_a",     op_a, 32'h22);
    chk("drain.1.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("drain.2.op_a",     op_a, 32'h33);
    chk("drain.2.valid",    {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();
    chk("drain.3.valid",    {31'd0, out_valid}, 32'd0);

    // Flush with both entries full
    out_ready = 1'b0;
    drive(1'b1, 32'h00221820, 32'h44, 32'd0);
    tick();
    drive(1'b1, 32'h00221820, 32'h55, 32'd0);
    tick();
    chk("flush.pre.in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush.in_ready",  {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    tick();
    chk("flush.no_resurrect", {31'd0, out_valid}, 32'd0);

    // Flush discards a same-cycle illegal input and its pulse
    drive(1'b1, 32'hFC000000, 32'd0, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    chk("flush_ill.illegal", {31'd0, illegal}, 32'd0);
    // Flush discards a same-cycle legal input
    drive(1'b1, 32'h00221820, 32'h66, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    chk("flush_leg.out_valid", {31'd0, out_valid}, 32'd0);
`ifdef ISSUE_ILLEGAL_CNT_EN
    chk("flush_ill.cnt", {16'd0, illegal_cnt}, 32'd2);
`endif

    // Asynchronous reset mid-stall
    out_ready = 1'b0;
    drive(1'b1, 32'h00221820, 32'h77, 32'h88);
    tick();
    drive(1'b1, 32'h00221820, 32'h99, 32'h88);
    tick();
    chk("prerst.valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst.in_ready",  {31'd0, in_ready}, 32'd1);
    chk("arst.op",        {28'd0, ALU_OP}, 32'd0);
    chk("arst.op_a",      op_a, 32'd0);
    chk("arst.op_b",      op_b, 32'd0);
    chk("arst.dest",      {27'd0, dest}, 32'd0);
`ifdef ISSUE_ILLEGAL_CNT_EN
    chk("arst.cnt",       {16'd0, illegal_cnt}, 32'd0);
`endif
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    tick();
    chk("postrst.in_ready",  {31'd0, in_ready}, 32'd1);
    chk("postrst.out_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
